// File: rtl/conv_job_scheduler_pkg.sv
// Shared types and geometry helpers for the convolution job schedulers.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int COORD_W = 16;
    typedef logic signed [COORD_W-1:0] coord_t;

    // Output feature-map side length; 0 flags an unusable geometry.
    function automatic int out_dim(input int n, input int f, input int p, input int s);
        if (s < 1) return 0;
        return (n - f + 2 * p) / s + 1;
    endfunction

    function automatic int total_jobs(input int out, input int nf);
        return out * out * nf;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_job_scheduler_lane_pick.sv
// Priority encoder: lowest set bit of avail_i plus a found flag.
module lane_pick #(
    parameter int W  = 16,
    parameter int IW = 4
) (
    input  logic [W-1:0]  avail_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (avail_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/conv_job_scheduler.sv
// Convolution job scheduler: one window job per cycle to the lowest free lane.
// Optional stall counter output enabled by CONV_JOB_SCHEDULER_PERF_EN.
module conv_job_scheduler
    import conv_pkg::*;
#(
    parameter int N     = 32,
    parameter int F     = 3,
    parameter int K     = 3,
    parameter int NF    = 4,
    parameter int P     = 0,
    parameter int S     = 1,
    parameter int NMULT = 16,
    parameter int CW    = 16,
    localparam int LW   = idx_w(NMULT),
    localparam int FW   = idx_w(NF),
    localparam int CHW  = $clog2(K + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 start,
    input  logic [NMULT-1:0]     lane_free,
    input  logic [NMULT-1:0]     lane_done,
    output logic                 disp_valid,
    output logic [LW-1:0]        disp_lane,
    output logic signed [CW-1:0] disp_irow,
    output logic signed [CW-1:0] disp_icol,
    output logic signed [CW-1:0] disp_orow,
    output logic signed [CW-1:0] disp_ocol,
    output logic [FW-1:0]        disp_filt,
    output logic [CHW-1:0]       disp_nch,
    output logic                 busy,
    output logic                 result_ready,
`ifdef CONV_JOB_SCHEDULER_PERF_EN
    output logic [31:0]          stall_cycles,
`endif
    output logic [31:0]          jobs_retired
);

    localparam int OUT   = out_dim(N, F, P, S);
    localparam int TOTAL = total_jobs(OUT, NF);

    if (OUT < 1 || S < 1 || TOTAL < 1) begin : g_bad_cfg
        $fatal(1, "conv_job_scheduler: output size or stride below 1");
    end

    state_t               state_q, state_d;
    logic [CW-1:0]        orow_q, orow_d, ocol_q, ocol_d;
    logic [FW-1:0]        filt_q, filt_d;
    logic [NMULT-1:0]     busy_q, busy_d;
    logic [31:0]          retired_q, retired_d;
    logic                 dvld_q, dvld_d;
    logic [LW-1:0]        dlane_q, dlane_d;
    logic signed [CW-1:0] dirow_q, dirow_d, dicol_q, dicol_d;
    logic signed [CW-1:0] dorow_q, dorow_d, docol_q, docol_d;
    logic [FW-1:0]        dfilt_q, dfilt_d;
    logic [CHW-1:0]       dnch_q, dnch_d;

    logic [NMULT-1:0] avail, done_mask;
    logic             found, launch, dispatch;
    logic [LW-1:0]    pick;

    assign avail     = lane_free & ~busy_q;
    assign done_mask = lane_done & busy_q;

    lane_pick #(.W(NMULT), .IW(LW)) u_pick (
        .avail_i (avail),
        .found_o (found),
        .idx_o   (pick)
    );

    always_comb begin
        state_d   = state_q;
        orow_d    = orow_q;
        ocol_d    = ocol_q;
        filt_d    = filt_q;
        busy_d    = busy_q & ~done_mask;
        retired_d = retired_q + 32'($countones(done_mask));
        launch    = 1'b0;
        dispatch  = 1'b0;
        dvld_d    = 1'b0;
        dlane_d   = '0;
        dirow_d   = '0;
        dicol_d   = '0;
        dorow_d   = '0;
        docol_d   = '0;
        dfilt_d   = '0;
        dnch_d    = '0;

        unique case (state_q)
            IDLE, DONE: launch = start;
            RUN:        dispatch = found;
            DRAIN:      if (busy_d == '0) state_d = DONE;
            default:    state_d = IDLE;
        endcase

        if (launch) begin
            state_d   = RUN;
            orow_d    = '0;
            ocol_d    = '0;
            filt_d    = '0;
            busy_d    = '0;
            retired_d = '0;
        end

        if (dispatch) begin
            busy_d  = busy_d | (NMULT'(1) << pick);
            dvld_d  = 1'b1;
            dlane_d = pick;
            dorow_d = $signed(orow_q);
            docol_d = $signed(ocol_q);
            dirow_d = $signed(orow_q) * $signed(CW'(S)) - $signed(CW'(P));
            dicol_d = $signed(ocol_q) * $signed(CW'(S)) - $signed(CW'(P));
            dfilt_d = filt_q;
            dnch_d  = CHW'(K);
            // ocol innermost, then orow, then filter
            if (ocol_q != CW'(OUT - 1)) begin
                ocol_d = ocol_q + 1'b1;
            end else begin
                ocol_d = '0;
                if (orow_q != CW'(OUT - 1)) begin
                    orow_d = orow_q + 1'b1;
                end else begin
                    orow_d = '0;
                    if (filt_q == FW'(NF - 1)) state_d = DRAIN;
                    else                       filt_d  = filt_q + 1'b1;
                end
            end
        end

        if (!en) begin
            state_d = IDLE;
            busy_d  = '0;
            dvld_d  = 1'b0;
            dlane_d = '0;
            dirow_d = '0;
            dicol_d = '0;
            dorow_d = '0;
            docol_d = '0;
            dfilt_d = '0;
            dnch_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            orow_q    <= '0;
            ocol_q    <= '0;
            filt_q    <= '0;
            busy_q    <= '0;
            retired_q <= '0;
            dvld_q    <= 1'b0;
            dlane_q   <= '0;
            dirow_q   <= '0;
            dicol_q   <= '0;
            dorow_q   <= '0;
            docol_q   <= '0;
            dfilt_q   <= '0;
            dnch_q    <= '0;
        end else begin
            state_q   <= state_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            filt_q    <= filt_d;
            busy_q    <= busy_d;
            retired_q <= retired_d;
            dvld_q    <= dvld_d;
            dlane_q   <= dlane_d;
            dirow_q   <= dirow_d;
            dicol_q   <= dicol_d;
            dorow_q   <= dorow_d;
            docol_q   <= docol_d;
            dfilt_q   <= dfilt_d;
            dnch_q    <= dnch_d;
        end
    end

`ifdef CONV_JOB_SCHEDULER_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Counts RUN cycles lost to lane starvation; saturates rather than wraps.
    always_comb begin
        stall_d = stall_q;
        if (en && launch)                                   stall_d = '0;
        else if (en && state_q == RUN && !found && stall_q != '1) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

    assign disp_valid   = dvld_q;
    assign disp_lane    = dlane_q;
    assign disp_irow    = dirow_q;
    assign disp_icol    = dicol_q;
    assign disp_orow    = dorow_q;
    assign disp_ocol    = docol_q;
    assign disp_filt    = dfilt_q;
    assign disp_nch     = dnch_q;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign result_ready = (state_q == DONE);
    assign jobs_retired = retired_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Scoreboard bench: two small scheduler instances (P0/S1 and P1/S2) share stimulus.
`timescale 1ns/1ps
module tb_conv_job_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, en, start_a, start_b, sel, auto_en;
    logic [3:0]  lane_free, done_auto, done_man, lane_done;
    assign lane_done = done_auto | done_man;

    logic               a_valid, b_valid, a_busy, b_busy, a_rr, b_rr;
    logic [1:0]         a_lane, b_lane, a_nch, b_nch;
    logic signed [15:0] a_irow, a_icol, a_orow, a_ocol;
    logic signed [15:0] b_irow, b_icol, b_orow, b_ocol;
    logic               a_filt, b_filt;
    logic [31:0]        a_ret, b_ret;
`ifdef CONV_JOB_SCHEDULER_PERF_EN
    logic [31:0]        a_stall, b_stall;
`endif

    conv_job_scheduler #(.N(5), .F(3), .K(3), .NF(2), .P(0), .S(1), .NMULT(4), .CW(16)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .start(start_a),
        .lane_free(lane_free), .lane_done(lane_done),
        .disp_valid(a_valid), .disp_lane(a_lane), .disp_irow(a_irow), .disp_icol(a_icol),
        .disp_orow(a_orow), .disp_ocol(a_ocol), .disp_filt(a_filt), .disp_nch(a_nch),
        .busy(a_busy), .result_ready(a_rr),
`ifdef CONV_JOB_SCHEDULER_PERF_EN
        .stall_cycles(a_stall),
`endif
        .jobs_retired(a_ret)
    );

    conv_job_scheduler #(.N(5), .F(3), .K(3), .NF(2), .P(1), .S(2), .NMULT(4), .CW(16)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .start(start_b),
        .lane_free(lane_free), .lane_done(lane_done),
        .disp_valid(b_valid), .disp_lane(b_lane), .disp_irow(b_irow), .disp_icol(b_icol),
        .disp_orow(b_orow), .disp_ocol(b_ocol), .disp_filt(b_filt), .disp_nch(b_nch),
        .busy(b_busy), .result_ready(b_rr),
`ifdef CONV_JOB_SCHEDULER_PERF_EN
        .stall_cycles(b_stall),
`endif
        .jobs_retired(b_ret)
    );

    logic               m_valid, m_filt;
    logic [1:0]         m_lane, m_nch;
    logic signed [15:0] m_irow, m_icol, m_orow, m_ocol;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_lane  = sel ? b_lane  : a_lane;
    assign m_nch   = sel ? b_nch   : a_nch;
    assign m_filt  = sel ? b_filt  : a_filt;
    assign m_irow  = sel ? b_irow  : a_irow;
    assign m_icol  = sel ? b_icol  : a_icol;
    assign m_orow  = sel ? b_orow  : a_orow;
    assign m_ocol  = sel ? b_ocol  : a_ocol;

    typedef struct {
        int filt; int orow; int ocol; int irow; int icol; int lane;
    } job_t;
    job_t sb[$];

    int vecs = 0, fails = 0, seen = 0;
    int first_irow, first_icol, last_irow, last_icol;

    task automatic chk(input string name, input longint act, input longint exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_job(input int f, input int r, input int c, input int s, input int p, input int lane);
        job_t j;
        j.filt = f; j.orow = r; j.ocol = c;
        j.irow = r * s - p; j.icol = c * s - p; j.lane = lane;
        sb.push_back(j);
    endtask

    task automatic push_layer(input int out, input int s, input int p, input int lane);
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < out; r++)
                for (int c = 0; c < out; c++)
                    push_job(f, r, c, s, p, lane);
    endtask

    // Monitor: pops one expected job per dispatch pulse.
    initial begin
        job_t e;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                seen++;
                if (sb.size() == 0) begin
                    vecs++; fails++;
                    $display("FAIL unexpected_dispatch: got filt=%0d orow=%0d ocol=%0d expected none",
                             m_filt, m_orow, m_ocol);
                end else begin
                    e = sb.pop_front();
                    chk("filt", m_filt, e.filt);
                    chk("orow", m_orow, e.orow);
                    chk("ocol", m_ocol, e.ocol);
                    chk("irow", m_irow, e.irow);
                    chk("icol", m_icol, e.icol);
                    chk("nch",  m_nch, 3);
                    if (e.lane >= 0) chk("lane", m_lane, e.lane);
                    if (seen == 1) begin first_irow = m_irow; first_icol = m_icol; end
                    last_irow = m_irow; last_icol = m_icol;
                end
            end
        end
    end

    // Lane model: each dispatched job finishes three cycles after it appears.
    int cnt[4];
    initial begin
        done_auto = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                done_auto[i] = 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0 && auto_en) done_auto[i] = 1'b1;
                end
            end
            if (m_valid) cnt[m_lane] = 3;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_start(input logic b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        step(1);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_seen(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (seen >= n) return;
            step(1);
        end
        chk("wait_dispatch_timeout", seen, n);
    endtask

    task automatic wait_rr(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sel ? b_rr : a_rr) return;
            step(1);
        end
        chk("wait_result_ready_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; en = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        auto_en = 1'b1; lane_free = '0; done_man = '0;
        step(3);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_rr, 0);
        chk("rst_retired", a_ret, 0);
        rstn = 1'b1; en = 1'b1;
        step(1);

        // full layer, four lanes
        lane_free = 4'b1111; seen = 0;
        push_layer(3, 1, 0, -1);
        pulse_start(1'b0);
        chk("run_busy", a_busy, 1);
        wait_rr(300);
        chk("l1_retired", a_ret, 18);
        chk("l1_count", seen, 18);
        chk("l1_sb_empty", sb.size(), 0);
        chk("l1_busy", a_busy, 0);

        // padding 1, stride 2
        sel = 1'b1; seen = 0;
        push_layer(3, 2, 1, -1);
        pulse_start(1'b1);
        wait_rr(300);
        chk("pad_first_irow", first_irow, -1);
        chk("pad_first_icol", first_icol, -1);
        chk("pad_last_irow", last_irow, 3);
        chk("pad_last_icol", last_icol, 3);
        chk("pad_retired", b_ret, 18);
        chk("pad_sb_empty", sb.size(), 0);
        sel = 1'b0;

        // single lane 2
        lane_free = 4'b0100; seen = 0;
        push_layer(3, 1, 0, 2);
        pulse_start(1'b0);
        wait_rr(600);
        chk("one_lane_retired", a_ret, 18);
        chk("one_lane_sb_empty", sb.size(), 0);
`ifdef CONV_JOB_SCHEDULER_PERF_EN
        chk("stall_cycles", a_stall, 68);
`endif

        // done pulse on an idle lane
        lane_free = 4'b0001; auto_en = 1'b0; seen = 0;
        push_job(0, 0, 0, 1, 0, 0);
        push_job(0, 0, 1, 1, 0, 3);
        pulse_start(1'b0);
        wait_seen(1, 20);
        done_man = 4'b1000; step(1); done_man = '0; step(1);
        chk("idle_done_retired", a_ret, 0);
        lane_free = 4'b1000;
        wait_seen(2, 20);
        lane_free = 4'b0000;
        step(2);
        chk("idle_done_sb_empty", sb.size(), 0);
        done_man = 4'b0001; step(1); done_man = '0; step(1);
        chk("busy_done_retired", a_ret, 1);
        en = 1'b0; step(1);
        chk("en_low_busy", a_busy, 0);
        en = 1'b1; auto_en = 1'b1; step(6);

        // enable dropped after seven dispatches
        lane_free = 4'b1111; seen = 0;
        push_job(0, 0, 0, 1, 0, -1); push_job(0, 0, 1, 1, 0, -1); push_job(0, 0, 2, 1, 0, -1);
        push_job(0, 1, 0, 1, 0, -1); push_job(0, 1, 1, 1, 0, -1); push_job(0, 1, 2, 1, 0, -1);
        push_job(0, 2, 0, 1, 0, -1);
        pulse_start(1'b0);
        wait_seen(7, 100);
        en = 1'b0; step(1);
        chk("drop_busy", a_busy, 0);
        chk("drop_valid", a_valid, 0);
        step(8);
        chk("drop_count", seen, 7);
        chk("drop_sb_empty", sb.size(), 0);
        en = 1'b1; step(2);
        seen = 0;
        push_layer(3, 1, 0, -1);
        pulse_start(1'b0);
        wait_rr(300);
        chk("restart_retired", a_ret, 18);
        chk("restart_count", seen, 18);

        // reset during drain
        seen = 0;
        push_layer(3, 1, 0, -1);
        pulse_start(1'b0);
        wait_seen(18, 300);
        chk("drain_busy", a_busy, 1);
        rstn = 1'b0; step(1);
        chk("drain_rst_busy", a_busy, 0);
        chk("drain_rst_ready", a_rr, 0);
        chk("drain_rst_valid", a_valid, 0);
        chk("drain_rst_retired", a_ret, 0);
        rstn = 1'b1; step(6);
        seen = 0;
        push_layer(3, 1, 0, -1);
        pulse_start(1'b0);
        wait_rr(300);
        chk("post_rst_retired", a_ret, 18);
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
- Next-generation convolution scheduler: walks every output pixel of every filter and dispatches one window job per cycle to a free multiplier lane.
- Tracks lane occupancy itself and handles stride, padding and fewer lanes than jobs by tiling over time. No fixed full/partial split.
- Sits between the layer controller (en/start) and the multiplier array (lane_free/lane_done). It emits window coordinates, not pixel data; the lane's fetch unit reads the image/filter buffers.

Parameters:
- N, 32, input image height/width.
- F, 3, filter height/width.
- K, 3, input channels per window (passed through as disp_nch).
- NF, 4, number of filters.
- P, 0, zero padding on each side.
- S, 1, stride (>=1).
- NMULT, 16, multiplier lanes.
- CW, 16, coordinate width (signed origins).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- en  in  1  block enable; low forces IDLE
- start  in  1  launch a layer (sampled only in IDLE/DONE)
- lane_free  in  NMULT  lane i externally available
- lane_done  in  NMULT  lane i finished its job (1-cycle pulse)
- disp_valid  out  1  job dispatched this cycle
- disp_lane  out  $clog2(NMULT)  target lane
- disp_irow  out  CW  signed top-left input row = orow*S-P
- disp_icol  out  CW  signed top-left input col = ocol*S-P
- disp_orow  out  CW  output row
- disp_ocol  out  CW  output col
- disp_filt  out  $clog2(NF)  filter index
- disp_nch  out  $clog2(K+1)  channel count, constant K
- busy  out  1  state is RUN or DRAIN
- result_ready  out  1  high while in DONE
- jobs_retired  out  32  lane_done pulses accepted this layer

Behaviour:
- Elaboration: OUT=(N-F+2P)/S+1 and TOTAL=OUT*OUT*NF are localparams. OUT<1 or S<1 is a fatal elaboration error.
- Reset (rstn=0 at clk edge): state IDLE; all outputs 0; lane busy mask 0; counters 0.
- States:
  - IDLE: start&en -> RUN; clears orow/ocol/filt, busy mask and jobs_retired.
  - RUN: each cycle, lane avail[i]=lane_free[i]&~busy_q[i]. If any avail, dispatch to the lowest-index avail lane, set busy_q[lane], and advance ocol, then orow, then filt (ocol innermost). After the TOTAL-th dispatch -> DRAIN.
  - DRAIN: no dispatch; when busy_q==0 (next-state value) -> DONE.
  - DONE: result_ready=1. start&en -> RUN with fresh counters. Otherwise hold.
- en=0 in any state -> IDLE next cycle; busy mask cleared; in-flight jobs abandoned. Takes priority over start.
- Dispatch outputs are registered: one-cycle latency from the decision cycle. disp_valid is a single-cycle pulse per job, with exactly TOTAL pulses per layer. Coordinate fields are 0 when disp_valid=0.
- lane_done[i] clears busy_q[i] and increments jobs_retired. lane_done on a non-busy lane is ignored and not counted.
- Same-cycle lane_done[i] and dispatch decision: avail uses busy_q before the clear, so lane i is reusable next cycle, never same cycle.
- Multiple lane_done bits in one cycle: all cleared; jobs_retired adds popcount.
- lane_free=0 for all lanes: RUN stalls, counters hold, no timeout.
- Padding: disp_irow/disp_icol may be negative (min -P) or exceed N-F. The lane zero-fills; the scheduler does not clip.
- start while busy: ignored.

Optional Feature:
- CONV_JOB_SCHEDULER_PERF_EN defined: adds output stall_cycles (32 bit). It counts RUN cycles with no dispatch due to no avail lane, clears on launch, and saturates at all-ones.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package conv_pkg:
  - localparam function for OUT/TOTAL
  - state enum {IDLE,RUN,DRAIN,DONE}
  - coordinate typedef coord_t (signed CW)
  - the lane-index width
- Natural sub-module lane_pick: priority encoder over avail giving found flag + lowest index (combinational, reusable by other schedulers).

Test Plan:
- N=5,F=3,S=1,P=0,NF=2,NMULT=4; lane_free all 1; each lane_done 3 cycles after dispatch -> 18 disp_valid pulses, order (f0,r0,c0..c2),(f0,r1,..)…, result_ready after last done, jobs_retired=18.
- Same config, P=1,S=2 -> OUT=3; first job irow=icol=-1, last job irow=icol=3, 18 jobs.
- lane_free=4'b0100 only -> every job on lane 2; no dispatch until prior lane_done is seen; PERF_EN stall_cycles equals gap cycles.
- lane_done pulse on an idle lane 3 while lane 0 is busy -> jobs_retired unchanged, busy_q[3] stays 0.
- en dropped mid-RUN after 7 dispatches -> IDLE next cycle, busy=0, no further pulses; restart emits 18 fresh jobs from (0,0,0).
- rstn low for 1 cycle during DRAIN -> all outputs 0, IDLE; start afterward -> normal layer.
